// File: rtl/prog_mem_arbiter_pkg.sv
// Shared types and default widths for the program-memory read arbiter.
// Optional feature macro used by the arbiter: PM_ARB_STARVE_GUARD_EN.
package prog_mem_arb_pkg;

  localparam int ADDR_BUS       = 11;
  localparam int DATA_SIZE      = 16;
  localparam int MAX_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_t;

  // Maps this cycle's grant pair onto the owner recorded for the next cycle.
  function automatic owner_t owner_of(input logic f_gnt, input logic d_gnt);
    owner_t o;
    case ({f_gnt, d_gnt})
      2'b10:   o = OWN_FETCH;
      2'b01:   o = OWN_DBG;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/prog_mem_arbiter_if.sv
// Request/grant/response bundle between the fetch stage, the debug unit,
// Prog_Mem and the arbiter.
interface prog_mem_arbiter_if
  import prog_mem_arb_pkg::*;
#(
  parameter int addr_bus  = ADDR_BUS,
  parameter int data_size = DATA_SIZE
);

  logic                 F_Req;
  logic [addr_bus-1:0]  F_Addr;
  logic                 F_Gnt;
  logic                 F_Valid;
  logic [data_size-1:0] F_Data;
  logic                 D_Req;
  logic [addr_bus-1:0]  D_Addr;
  logic                 D_Gnt;
  logic                 D_Valid;
  logic [data_size-1:0] D_Data;
  logic [addr_bus-1:0]  Mem_Addr;
  logic [data_size-1:0] Mem_Data;

  modport slave (
    input  F_Req, F_Addr, D_Req, D_Addr, Mem_Data,
    output F_Gnt, F_Valid, F_Data, D_Gnt, D_Valid, D_Data, Mem_Addr
  );

  modport master (
    output F_Req, F_Addr, D_Req, D_Addr, Mem_Data,
    input  F_Gnt, F_Valid, F_Data, D_Gnt, D_Valid, D_Data, Mem_Addr
  );

endinterface

// File: rtl/prog_mem_arbiter_streak.sv
// Saturating streak counter: clear wins over increment, sat flags the ceiling.
module pm_arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_r;

  // Count up on inc, stop at MAX, return to zero on reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != W'(MAX))) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign sat = (cnt_r == W'(MAX));

endmodule

// File: rtl/prog_mem_arbiter.sv
// Arbitrates Prog_Mem's single combinational read port between fetch and debug.
// Define PM_ARB_STARVE_GUARD_EN to let debug break a long run of fetch grants.
module prog_mem_arbiter
  import prog_mem_arb_pkg::*;
#(
  parameter int addr_bus  = ADDR_BUS,
  parameter int data_size = DATA_SIZE
`ifdef PM_ARB_STARVE_GUARD_EN
  , parameter int MAX_STREAK = MAX_STREAK_DEF
`endif
) (
  input  logic                Clk,
  input  logic                Reset,
  prog_mem_arbiter_if.slave   bus,
  output owner_t              owner
);

  logic                 f_gnt_s;
  logic                 d_gnt_s;
  logic                 d_turn_s;
  logic [addr_bus-1:0]  mem_addr_s;
  logic [addr_bus-1:0]  last_addr_r;
  logic                 f_valid_r;
  logic                 d_valid_r;
  logic [data_size-1:0] f_data_r;
  logic [data_size-1:0] d_data_r;
  owner_t               owner_r;

`ifdef PM_ARB_STARVE_GUARD_EN
  logic sat_s;

  pm_arb_streak_ctr #(.MAX(MAX_STREAK)) u_streak (
    .clk (Clk),
    .rst (Reset),
    .clr (d_gnt_s | ~bus.D_Req),
    .inc (f_gnt_s & bus.D_Req),
    .sat (sat_s)
  );

  assign d_turn_s = sat_s;
`else
  assign d_turn_s = 1'b0;
`endif

  // Grant selection; fetch wins contention unless debug has waited out its streak.
  always_comb begin
    f_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (Reset) begin
      f_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (bus.F_Req && bus.D_Req) begin
      if (d_turn_s) begin
        d_gnt_s = 1'b1;
      end else begin
        f_gnt_s = 1'b1;
      end
    end else if (bus.F_Req) begin
      f_gnt_s = 1'b1;
    end else if (bus.D_Req) begin
      d_gnt_s = 1'b1;
    end else begin
      f_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Memory address follows the grant; otherwise it parks on the last granted address.
  always_comb begin
    mem_addr_s = last_addr_r;
    if (f_gnt_s) begin
      mem_addr_s = bus.F_Addr;
    end else if (d_gnt_s) begin
      mem_addr_s = bus.D_Addr;
    end else begin
      mem_addr_s = last_addr_r;
    end
  end

  // Capture the memory word for the granted side; the other side's data holds.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      f_valid_r   <= 1'b0;
      d_valid_r   <= 1'b0;
      f_data_r    <= {data_size{1'b0}};
      d_data_r    <= {data_size{1'b0}};
      last_addr_r <= {addr_bus{1'b0}};
      owner_r     <= OWN_NONE;
    end else begin
      f_valid_r <= f_gnt_s;
      d_valid_r <= d_gnt_s;
      if (f_gnt_s) begin
        f_data_r <= bus.Mem_Data;
      end
      if (d_gnt_s) begin
        d_data_r <= bus.Mem_Data;
      end
      if (f_gnt_s || d_gnt_s) begin
        last_addr_r <= mem_addr_s;
      end
      owner_r <= owner_of(f_gnt_s, d_gnt_s);
    end
  end

  assign bus.F_Gnt    = f_gnt_s;
  assign bus.D_Gnt    = d_gnt_s;
  assign bus.Mem_Addr = mem_addr_s;
  assign bus.F_Valid  = f_valid_r;
  assign bus.D_Valid  = d_valid_r;
  assign bus.F_Data   = f_data_r;
  assign bus.D_Data   = d_data_r;
  assign owner        = owner_r;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter with a behavioural Prog_Mem array
// and a cycle-level reference model of the arbitration rules.
module tb_prog_mem_arbiter;
  import prog_mem_arb_pkg::*;

`ifdef PM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int MAXS = 4;

  logic   clk;
  logic   Reset;
  owner_t owner;

  prog_mem_arbiter_if bus ();

  prog_mem_arbiter dut (
    .Clk   (clk),
    .Reset (Reset),
    .bus   (bus),
    .owner (owner)
  );

  logic [15:0] mem [0:2047];
  assign bus.Mem_Data = mem[bus.Mem_Addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;

  // Reference model state
  logic        m_fv, m_dv;
  logic [15:0] m_fd, m_dd;
  logic [10:0] m_last;
  logic [1:0]  m_owner;
  int          m_streak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic fr, input logic [10:0] fa,
                     input logic dr, input logic [10:0] da,
                     output logic fg, output logic dg, output logic obs_dg);
    logic [10:0] ea;
    logic [15:0] md;
    @(negedge clk);
    Reset = rst;
    bus.F_Req = fr; bus.F_Addr = fa;
    bus.D_Req = dr; bus.D_Addr = da;
    #1;
    fg = 1'b0; dg = 1'b0;
    if (!rst) begin
      if (fr && dr) begin
        if (GUARD && m_streak == MAXS) dg = 1'b1;
        else fg = 1'b1;
      end else begin
        fg = fr;
        dg = dr;
      end
    end
    obs_dg = bus.D_Gnt;
    chk("f_gnt", bus.F_Gnt, fg);
    chk("d_gnt", bus.D_Gnt, dg);
    ea = fg ? fa : (dg ? da : m_last);
    if (!rst) chk("mem_addr", bus.Mem_Addr, ea);
    md = mem[ea];
    if (rst || dg || !dr) m_streak = 0;
    else if (fg && m_streak < MAXS) m_streak = m_streak + 1;
    @(posedge clk);
    #1;
    if (rst) begin
      m_fv = 1'b0; m_dv = 1'b0; m_fd = 16'h0; m_dd = 16'h0;
      m_last = 11'h0; m_owner = 2'd0;
    end else begin
      m_fv = fg; m_dv = dg;
      if (fg) m_fd = md;
      if (dg) m_dd = md;
      if (fg || dg) m_last = ea;
      m_owner = fg ? 2'd1 : (dg ? 2'd2 : 2'd0);
    end
    chk("f_valid", bus.F_Valid, m_fv);
    chk("f_data",  bus.F_Data,  m_fd);
    chk("d_valid", bus.D_Valid, m_dv);
    chk("d_data",  bus.D_Data,  m_dd);
    chk("owner",   owner,       m_owner);
  endtask

  initial begin
    logic fg, dg, odg;
    logic fr, dr, rst, hold_f, hold_d;
    logic [10:0] fa, da;
    int first_dg;

    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    Reset = 1'b1;
    bus.F_Req = 1'b0; bus.F_Addr = 11'h0;
    bus.D_Req = 1'b0; bus.D_Addr = 11'h0;
    m_fv = 1'b0; m_dv = 1'b0; m_fd = 16'h0; m_dd = 16'h0;
    m_last = 11'h0; m_owner = 2'd0; m_streak = 0;

    // Reset held two cycles with fetch requesting, then released
    cyc(1'b1, 1'b1, 11'd7, 1'b0, 11'd0, fg, dg, odg);
    cyc(1'b1, 1'b1, 11'd7, 1'b0, 11'd0, fg, dg, odg);
    chk("rst_f_data", bus.F_Data, 32'h0);
    cyc(1'b0, 1'b1, 11'd7, 1'b0, 11'd0, fg, dg, odg);

    // Fetch stream 0..20
    for (int i = 0; i <= 20; i++) cyc(1'b0, 1'b1, 11'(i), 1'b0, 11'd0, fg, dg, odg);
    chk("stream_last", bus.F_Data, {16'h0, mem[20]});

    // Debug read of address 5 with fetch idle
    cyc(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, fg, dg, odg);
    cyc(1'b0, 1'b0, 11'd0, 1'b1, 11'd5, fg, dg, odg);
    chk("dbg5_data", bus.D_Data, {16'h0, mem[5]});
    cyc(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, fg, dg, odg);

    // Both held: debug waits for the starvation guard, or forever without it
    first_dg = 0;
    dr = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 1'b1, 11'd100, dr, 11'd200, fg, dg, odg);
      if (odg && first_dg == 0) first_dg = k;
      if (dg) dr = 1'b0;
    end
    chk("dgnt_cycle", 32'(first_dg), GUARD ? 32'd5 : 32'd0);
    cyc(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, fg, dg, odg);

    // Reset pulsed in the cycle after a fetch grant
    cyc(1'b0, 1'b1, 11'd9, 1'b0, 11'd0, fg, dg, odg);
    cyc(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, fg, dg, odg);
    cyc(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, fg, dg, odg);
    chk("post_rst_addr", bus.Mem_Addr, 32'h0);

    // Requests drop: address parks on last grant
    cyc(1'b0, 1'b1, 11'h3AB, 1'b0, 11'd0, fg, dg, odg);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, fg, dg, odg);
    chk("park_addr", bus.Mem_Addr, 32'h3AB);

    // Randomized traffic obeying hold-until-grant
    hold_f = 1'b0; hold_d = 1'b0; fr = 1'b0; dr = 1'b0; fa = 11'h0; da = 11'h0;
    for (int n = 0; n < 400; n++) begin
      if (!hold_f) begin fr = ($urandom_range(0, 3) != 0); fa = 11'($urandom); end
      if (!hold_d) begin dr = ($urandom_range(0, 1) != 0); da = 11'($urandom); end
      rst = ($urandom_range(0, 63) == 0);
      cyc(rst, fr, fa, dr, da, fg, dg, odg);
      hold_f = fr && !fg && !rst;
      hold_d = dr && !dg && !rst;
    end

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
